// File: rtl/ref_lock_monitor_pkg.sv
// ---------------------------------------------------------------------------
// ref_lock_monitor_pkg : state encoding and tolerance helper for the monitor
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ref_lock_monitor_pkg;

  localparam logic [1:0] IDLE_ENC    = 2'd0;
  localparam logic [1:0] ACQUIRE_ENC = 2'd1;
  localparam logic [1:0] LOCKED_ENC  = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = IDLE_ENC,
    ACQUIRE = ACQUIRE_ENC,
    LOCKED  = LOCKED_ENC
  } state_e;

  // Wide signed difference so no period value can wrap into tolerance.
  function automatic logic in_tol(input longint p, input longint exp_p, input longint tol);
    longint diff;
    diff = p - exp_p;
    return (diff <= tol) && (diff >= -tol);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_rise_det.sv
// ---------------------------------------------------------------------------
// sync_rise_det : STAGES-flop synchroniser with a registered rising-edge pulse
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_rise_det #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic rise_o
);

  if (STAGES < 2) begin : g_stages_check
    $error("sync_rise_det: STAGES must be at least 2");
  end

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;
  logic              rise_q, rise_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
    prev_d = sync_q[STAGES-1];
    rise_d = sync_q[STAGES-1] & ~prev_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  assign rise_o = rise_q;

endmodule

`default_nettype wire

// File: rtl/ref_lock_monitor.sv
// ---------------------------------------------------------------------------
// ref_lock_monitor : measures reference clock periods, tracks lock with
// hysteresis, flags out-of-tolerance periods and loss of reference.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ref_lock_monitor
  import ref_lock_monitor_pkg::*;
#(
  parameter int CNT_WIDTH   = 16,
  parameter int EXP_PERIOD  = 1000,
  parameter int TOL         = 4,
  parameter int LOCK_CNT    = 8,
  parameter int UNLOCK_CNT  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 ref_i,
  input  logic                 en_i,
  output logic                 lock_o,
  output logic [CNT_WIDTH-1:0] period_o,
  output logic                 period_valid_o,
  output logic                 err_o,
  output logic                 ref_lost_o
);

  if (!(((longint'(1) << CNT_WIDTH) > longint'(2 * EXP_PERIOD + 1)) &&
        (LOCK_CNT >= 1) && (UNLOCK_CNT >= 1))) begin : g_param_check
    $error("ref_lock_monitor: illegal parameter combination");
  end

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);
  localparam logic [CNT_WIDTH-1:0] C_TIMEOUT = CNT_WIDTH'(2 * EXP_PERIOD);

  logic ref_edge;

  sync_rise_det #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (ref_i),
    .rise_o (ref_edge)
  );

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [GW-1:0]        good_cnt_q, good_cnt_d;
  logic [BW-1:0]        bad_cnt_q, bad_cnt_d;
  logic                 lock_q, lock_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic                 lost_q, lost_d;
  logic                 good;
  logic [GW-1:0]        good_inc;
  logic [BW-1:0]        bad_inc;

  always_comb begin
    good       = in_tol(longint'(cnt_q), longint'(EXP_PERIOD), longint'(TOL));
    good_inc   = good_cnt_q + 1'b1;
    bad_inc    = bad_cnt_q + 1'b1;
    state_d    = state_q;
    cnt_d      = cnt_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    lock_d     = lock_q;
    period_d   = period_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    lost_d     = lost_q;

    if (ref_edge) begin
      cnt_d = CNT_WIDTH'(1);
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (ref_edge) begin
          state_d    = ACQUIRE;
          good_cnt_d = '0;
          bad_cnt_d  = '0;
          lost_d     = 1'b0;
        end
      end
      ACQUIRE, LOCKED: begin
        // An edge coinciding with the timeout value is a normal measurement.
        if (ref_edge) begin
          period_d = cnt_q;
          valid_d  = 1'b1;
          if (state_q == ACQUIRE) begin
            if (good) begin
              good_cnt_d = good_inc;
              if (good_inc == GW'(LOCK_CNT)) begin
                state_d   = LOCKED;
                lock_d    = 1'b1;
                bad_cnt_d = '0;
              end
            end else begin
              good_cnt_d = '0;
              err_d      = 1'b1;
            end
          end else begin
            if (good) begin
              bad_cnt_d = '0;
            end else begin
              err_d = 1'b1;
              if (bad_inc == BW'(UNLOCK_CNT)) begin
                lock_d     = 1'b0;
                state_d    = ACQUIRE;
                good_cnt_d = '0;
                bad_cnt_d  = '0;
              end else begin
                bad_cnt_d = bad_inc;
              end
            end
          end
        end else if (cnt_q == C_TIMEOUT) begin
          lost_d     = 1'b1;
          lock_d     = 1'b0;
          state_d    = IDLE;
          good_cnt_d = '0;
          bad_cnt_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Soft reset: everything but the reported period restarts.
    if (!en_i) begin
      state_d    = IDLE;
      cnt_d      = '0;
      good_cnt_d = '0;
      bad_cnt_d  = '0;
      lock_d     = 1'b0;
      valid_d    = 1'b0;
      err_d      = 1'b0;
      lost_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      lock_q     <= 1'b0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      lock_q     <= lock_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      lost_q     <= lost_d;
    end
  end

  assign lock_o         = lock_q;
  assign period_o       = period_q;
  assign period_valid_o = valid_q;
  assign err_o          = err_q;
  assign ref_lost_o     = lost_q;

endmodule

`default_nettype wire

// File: tb/tb_ref_lock_monitor.sv
// ---------------------------------------------------------------------------
// tb_ref_lock_monitor : scoreboard bench for ref_lock_monitor
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ref_lock_monitor;

  localparam int EXP = 20;
  localparam int TOLV = 1;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic       ref_i;
  logic       en_i;
  logic       lock_o;
  logic [7:0] period_o;
  logic       period_valid_o;
  logic       err_o;
  logic       ref_lost_o;

  ref_lock_monitor #(
    .CNT_WIDTH   (8),
    .EXP_PERIOD  (EXP),
    .TOL         (TOLV),
    .LOCK_CNT    (4),
    .UNLOCK_CNT  (2),
    .SYNC_STAGES (2)
  ) dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .ref_i          (ref_i),
    .en_i           (en_i),
    .lock_o         (lock_o),
    .period_o       (period_o),
    .period_valid_o (period_valid_o),
    .err_o          (err_o),
    .ref_lost_o     (ref_lost_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0] period;
    logic       err;
    logic       lock;
  } exp_t;

  exp_t sb[$];
  exp_t e_m;
  int   n_total = 0;
  int   n_bad   = 0;
  int   cyc     = 0;
  int   last_valid_cyc = 0;
  int   since   = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_total++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp_v, cyc);
    end
  endtask

  // Output monitor: every reported period is matched against the scoreboard.
  always @(negedge clk_i) begin
    if (period_valid_o) begin
      last_valid_cyc = cyc;
      if (sb.size() == 0) begin
        chk("valid_without_expect", 32'(period_valid_o), 32'd0);
      end else begin
        e_m = sb.pop_front();
        chk("period", 32'(period_o), 32'(e_m.period));
        chk("err", 32'(err_o), 32'(e_m.err));
        chk("lock", 32'(lock_o), 32'(e_m.lock));
        chk("lost_at_valid", 32'(ref_lost_o), 32'd0);
      end
    end else if (err_o) begin
      chk("stray_err", 32'(err_o), 32'd0);
    end
  end

  task automatic wait_cyc(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk_i);
      since++;
      if (since == 5) ref_i = 1'b0;
    end
  endtask

  task automatic first_rise();
    ref_i = 1'b1;
    since = 0;
  endtask

  // Close a reference period of n cycles and record what the monitor must report.
  task automatic edge_after(input int n, input bit lck);
    exp_t e;
    int   d;
    while (since < n) wait_cyc(1);
    ref_i = 1'b1;
    since = 0;
    d = n - EXP;
    e.period = 8'(n);
    e.err    = (d > TOLV) || (d < -TOLV);
    e.lock   = lck;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) wait_cyc(1);
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic acquire4();
    edge_after(20, 1'b0);
    edge_after(20, 1'b0);
    edge_after(20, 1'b0);
    edge_after(20, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn_i = 1'b0;
    en_i   = 1'b1;
    ref_i  = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_lock", 32'(lock_o), 32'd0);
    chk("rst_period", 32'(period_o), 32'd0);
    chk("rst_valid", 32'(period_valid_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_lost", 32'(ref_lost_o), 32'd0);
    rstn_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // Clean acquisition at the nominal period.
    first_rise();
    acquire4();
    drain();

    // Error mid-acquisition restarts the good-period count.
    wait_cyc(6);
    en_i = 1'b0;
    @(negedge clk_i);
    chk("soft_rst_lock", 32'(lock_o), 32'd0);
    en_i = 1'b1;
    first_rise();
    edge_after(20, 1'b0);
    edge_after(21, 1'b0);
    edge_after(19, 1'b0);
    edge_after(22, 1'b0);
    acquire4();
    drain();

    // Hysteresis: one bad period is tolerated, two in a row drop lock.
    edge_after(25, 1'b1);
    edge_after(20, 1'b1);
    edge_after(25, 1'b1);
    edge_after(25, 1'b0);
    acquire4();
    drain();

    // Loss of reference and recovery.
    for (int i = 0; i < 100 && !ref_lost_o; i++) wait_cyc(1);
    chk("lost_seen", 32'(ref_lost_o), 32'd1);
    chk("lost_delay", 32'(cyc - last_valid_cyc), 32'd40);
    chk("lock_after_lost", 32'(lock_o), 32'd0);
    first_rise();
    wait_cyc(3);
    chk("lost_held", 32'(ref_lost_o), 32'd1);
    wait_cyc(1);
    chk("lost_cleared", 32'(ref_lost_o), 32'd0);
    acquire4();
    drain();

    // One-cycle reset while locked.
    wait_cyc(6);
    rstn_i = 1'b0;
    @(negedge clk_i);
    rstn_i = 1'b1;
    chk("mid_rst_lock", 32'(lock_o), 32'd0);
    chk("mid_rst_period", 32'(period_o), 32'd0);
    chk("mid_rst_valid", 32'(period_valid_o), 32'd0);
    chk("mid_rst_err", 32'(err_o), 32'd0);
    chk("mid_rst_lost", 32'(ref_lost_o), 32'd0);

    // Enable low while locked keeps the last period.
    first_rise();
    acquire4();
    drain();
    wait_cyc(6);
    en_i = 1'b0;
    @(negedge clk_i);
    chk("en_low_lock", 32'(lock_o), 32'd0);
    chk("en_low_period", 32'(period_o), 32'd20);
    chk("en_low_lost", 32'(ref_lost_o), 32'd0);
    chk("en_low_valid", 32'(period_valid_o), 32'd0);
    en_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // Period equal to the timeout value: the edge wins.
    first_rise();
    edge_after(40, 1'b0);
    edge_after(40, 1'b0);
    drain();
    chk("edge_wins_lost", 32'(ref_lost_o), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
